// File: rtl/tlc_pkg.sv
// Shared types and helpers for the multi-phase traffic controller.
// The demand-skip search is used only when TLC_DEMAND_SKIP_EN is defined in the top level.
package tlc_pkg;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_FLASH  = 2'd3
    } tlc_state_e;

    // Upper bound on the phase count handled by the demand search.
    localparam int unsigned TLC_MAX_PHASES = 64;

    // The phase after cur, in cyclic order. With skip_en set, the first phase
    // after cur that has demand wins. cur itself is checked last. With no
    // demand anywhere, the result is plain round-robin.
    function automatic int unsigned tlc_next_phase(
        input int unsigned                cur,
        input int unsigned                n_phases,
        input logic [TLC_MAX_PHASES-1:0]  demand,
        input logic                       skip_en
    );
        int unsigned nxt;
        int unsigned idx;
        logic        found;
        nxt   = (cur + 32'd1 >= n_phases) ? 32'd0 : cur + 32'd1;
        found = 1'b0;
        if (skip_en) begin
            for (int unsigned k = 1; k <= TLC_MAX_PHASES; k++) begin
                idx = cur + k;
                if (idx >= n_phases) begin
                    idx = idx - n_phases;
                end
                if (!found && (k <= n_phases) && demand[idx[5:0]]) begin
                    nxt   = idx;
                    found = 1'b1;
                end
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/tlc_interval_timer.sv
// Loadable interval down-counter. done_o fires on the enabled cycle where the count is 1.
// A load takes priority over the decrement.
module tlc_interval_timer
    import tlc_pkg::*;
#(
    parameter int          CNT_W     = 16,
    parameter int unsigned RESET_VAL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (enable_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= CNT_W'(RESET_VAL);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = enable_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/multi_phase_traffic_controller.sv
// Round-robin GREEN -> YELLOW -> ALL-RED sequencer over N_PHASES approaches, with maintenance flashing yellow.
// The TLC_DEMAND_SKIP_EN define makes the next green go to the next phase that has demand.
module multi_phase_traffic_controller
    import tlc_pkg::*;
#(
    parameter int N_PHASES   = 2,
    parameter int CNT_W      = 16,
    parameter int GREEN_CYC  = 50,
    parameter int YELLOW_CYC = 10,
    parameter int ALLRED_CYC = 5,
    parameter int FLASH_CYC  = 25,
    localparam int PH_W      = (N_PHASES > 1) ? $clog2(N_PHASES) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                flash_req,
    input  logic [N_PHASES-1:0] demand,
    output logic [N_PHASES-1:0] R,
    output logic [N_PHASES-1:0] Y,
    output logic [N_PHASES-1:0] G,
    output logic [PH_W-1:0]     phase,
    output logic                cycle_start
);

`ifdef TLC_DEMAND_SKIP_EN
    localparam logic SKIP_EN = 1'b1;
`else
    localparam logic SKIP_EN = 1'b0;
`endif

    tlc_state_e          state_q, state_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic                flash_on_q, flash_on_d;
    logic [N_PHASES-1:0] r_q, r_d, y_q, y_d, g_q, g_d;
    logic                cs_q, cs_d;

    logic                     tmr_load;
    logic [CNT_W-1:0]         tmr_val;
    logic                     tmr_done;
    logic [TLC_MAX_PHASES-1:0] demand_ext;

    assign demand_ext = TLC_MAX_PHASES'(demand);

    tlc_interval_timer #(
        .CNT_W     (CNT_W),
        .RESET_VAL (ALLRED_CYC)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .enable_i   (enable),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // Every state change happens on timer expiry, so the timer reloads on each one.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        flash_on_d = flash_on_q;
        tmr_load   = 1'b0;
        tmr_val    = CNT_W'(ALLRED_CYC);
        if (tmr_done) begin
            tmr_load = 1'b1;
            case (state_q)
                ST_GREEN: begin
                    state_d = ST_YELLOW;
                    tmr_val = CNT_W'(YELLOW_CYC);
                end
                ST_YELLOW: begin
                    state_d = ST_ALLRED;
                    tmr_val = CNT_W'(ALLRED_CYC);
                end
                ST_ALLRED: begin
                    if (flash_req) begin
                        state_d    = ST_FLASH;
                        flash_on_d = 1'b1;
                        tmr_val    = CNT_W'(FLASH_CYC);
                    end else begin
                        state_d = ST_GREEN;
                        phase_d = PH_W'(tlc_next_phase(32'(phase_q), N_PHASES,
                                                       demand_ext, SKIP_EN));
                        tmr_val = CNT_W'(GREEN_CYC);
                    end
                end
                ST_FLASH: begin
                    if (flash_req) begin
                        flash_on_d = ~flash_on_q;
                        tmr_val    = CNT_W'(FLASH_CYC);
                    end else begin
                        state_d    = ST_ALLRED;
                        phase_d    = PH_W'(N_PHASES - 1);
                        flash_on_d = 1'b0;
                        tmr_val    = CNT_W'(ALLRED_CYC);
                    end
                end
            endcase
        end
    end

    // Lamps are decoded from the next state, so they register together with it.
    always_comb begin
        r_d = '1;
        y_d = '0;
        g_d = '0;
        case (state_d)
            ST_GREEN: begin
                g_d[phase_d] = 1'b1;
                r_d[phase_d] = 1'b0;
            end
            ST_YELLOW: begin
                y_d[phase_d] = 1'b1;
                r_d[phase_d] = 1'b0;
            end
            ST_FLASH: begin
                r_d = '0;
                y_d = {N_PHASES{flash_on_d}};
            end
            default: ;
        endcase
        cs_d = tmr_done && (state_d == ST_GREEN) && (phase_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_ALLRED;
            phase_q    <= PH_W'(N_PHASES - 1);
            flash_on_q <= 1'b0;
            r_q        <= '1;
            y_q        <= '0;
            g_q        <= '0;
            cs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            flash_on_q <= flash_on_d;
            r_q        <= r_d;
            y_q        <= y_d;
            g_q        <= g_d;
            cs_q       <= cs_d;
        end
    end

    assign R           = r_q;
    assign Y           = y_q;
    assign G           = g_q;
    assign phase       = phase_q;
    assign cycle_start = cs_q;

endmodule

// File: tb/tb_multi_phase_traffic_controller.sv
// Directed bench for multi_phase_traffic_controller (default build, TLC_DEMAND_SKIP_EN undefined).
// Uses N_PHASES=3, GREEN=4, YELLOW=2, ALLRED=1, FLASH=3, followed by a short randomised invariant sweep.
module tb_multi_phase_traffic_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       flash_req;
    logic [2:0] demand;
    logic [2:0] R, Y, G;
    logic [1:0] phase;
    logic       cycle_start;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    multi_phase_traffic_controller #(
        .N_PHASES   (3),
        .CNT_W      (16),
        .GREEN_CYC  (4),
        .YELLOW_CYC (2),
        .ALLRED_CYC (1),
        .FLASH_CYC  (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .flash_req   (flash_req),
        .demand      (demand),
        .R           (R),
        .Y           (Y),
        .G           (G),
        .phase       (phase),
        .cycle_start (cycle_start)
    );

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed RYG/ph/cs=%b_%b_%b/%b/%b required=%b_%b_%b/%b/%b", tag,
                   obs[11:9], obs[8:6], obs[5:3], obs[2:1], obs[0],
                   exp[11:9], exp[8:6], exp[5:3], exp[2:1], exp[0]);
        end
    endtask

    task automatic expect_all(input string tag, input logic [2:0] r, input logic [2:0] y,
                              input logic [2:0] g, input logic [1:0] ph, input logic cs);
        chk(tag, {R, Y, G, phase, cycle_start}, {r, y, g, ph, cs});
    endtask

    // Phase index is not checked while flashing.
    task automatic expect_lamps(input string tag, input logic [2:0] r, input logic [2:0] y,
                                input logic [2:0] g, input logic cs);
        chk(tag, {R, Y, G, 2'b00, cycle_start}, {r, y, g, 2'b00, cs});
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // One full phase: 4 green, 2 yellow, 1 all-red.
    task automatic phase_seq(input int ph, input logic first_cs);
        logic [2:0] oh;
        oh = 3'(1 << ph);
        for (int i = 0; i < 4; i++) begin
            step();
            expect_all($sformatf("green_p%0d_c%0d", ph, i), ~oh, 3'b000, oh, 2'(ph),
                       (i == 0) ? first_cs : 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            expect_all($sformatf("yellow_p%0d_c%0d", ph, i), ~oh, oh, 3'b000, 2'(ph), 1'b0);
        end
        step();
        expect_all($sformatf("allred_p%0d", ph), 3'b111, 3'b000, 3'b000, 2'(ph), 1'b0);
        $display("phase %0d sequence checked at %0t", ph, $time);
    endtask

    initial begin
        logic [2:0] prev_r, prev_y, prev_g;
        logic       ok;

        reset     = 1'b1;
        enable    = 1'b1;
        flash_req = 1'b0;
        demand    = 3'b000;

        // Reset values, then the basic round-robin.
        step();
        expect_all("reset_state", 3'b111, 3'b000, 3'b000, 2'd2, 1'b0);
        step();
        reset = 1'b0;
        phase_seq(0, 1'b1);
        phase_seq(1, 1'b0);
        phase_seq(2, 1'b0);

        // Freeze for 10 cycles during the second green cycle of phase 1.
        phase_seq(0, 1'b1);
        step(); expect_all("frz_green_c0", 3'b101, 3'b000, 3'b010, 2'd1, 1'b0);
        step(); expect_all("frz_green_c1", 3'b101, 3'b000, 3'b010, 2'd1, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            expect_all($sformatf("frz_hold_%0d", i), 3'b101, 3'b000, 3'b010, 2'd1, 1'b0);
        end
        enable = 1'b1;
        step(); expect_all("frz_green_c2", 3'b101, 3'b000, 3'b010, 2'd1, 1'b0);
        step(); expect_all("frz_green_c3", 3'b101, 3'b000, 3'b010, 2'd1, 1'b0);
        step(); expect_all("frz_yellow_c0", 3'b101, 3'b010, 3'b000, 2'd1, 1'b0);
        step(); expect_all("frz_yellow_c1", 3'b101, 3'b010, 3'b000, 2'd1, 1'b0);
        step(); expect_all("frz_allred", 3'b111, 3'b000, 3'b000, 2'd1, 1'b0);
        $display("freeze transaction checked at %0t", $time);
        phase_seq(2, 1'b0);

        // Flash request raised mid-green: the phase completes, then the flashing starts.
        phase_seq(0, 1'b1);
        step(); expect_all("fl_green_c0", 3'b101, 3'b000, 3'b010, 2'd1, 1'b0);
        step(); expect_all("fl_green_c1", 3'b101, 3'b000, 3'b010, 2'd1, 1'b0);
        flash_req = 1'b1;
        step(); expect_all("fl_green_c2", 3'b101, 3'b000, 3'b010, 2'd1, 1'b0);
        step(); expect_all("fl_green_c3", 3'b101, 3'b000, 3'b010, 2'd1, 1'b0);
        step(); expect_all("fl_yellow_c0", 3'b101, 3'b010, 3'b000, 2'd1, 1'b0);
        step(); expect_all("fl_yellow_c1", 3'b101, 3'b010, 3'b000, 2'd1, 1'b0);
        step(); expect_all("fl_allred", 3'b111, 3'b000, 3'b000, 2'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_lamps($sformatf("flash_on_%0d", i), 3'b000, 3'b111, 3'b000, 1'b0);
        end
        step(); expect_lamps("flash_off_0", 3'b000, 3'b000, 3'b000, 1'b0);
        flash_req = 1'b0;
        step(); expect_lamps("flash_off_1", 3'b000, 3'b000, 3'b000, 1'b0);
        step(); expect_lamps("flash_off_2", 3'b000, 3'b000, 3'b000, 1'b0);
        step(); expect_all("flash_exit_allred", 3'b111, 3'b000, 3'b000, 2'd2, 1'b0);
        $display("flash transaction checked at %0t", $time);
        phase_seq(0, 1'b1);

        // Asynchronous reset in the middle of the yellow interval.
        for (int i = 0; i < 4; i++) begin
            step();
            expect_all($sformatf("ar_green_c%0d", i), 3'b101, 3'b000, 3'b010, 2'd1, 1'b0);
        end
        step(); expect_all("ar_yellow_c0", 3'b101, 3'b010, 3'b000, 2'd1, 1'b0);
        #2 reset = 1'b1;
        #1 expect_all("async_reset_now", 3'b111, 3'b000, 3'b000, 2'd2, 1'b0);
        step(); expect_all("async_reset_hold", 3'b111, 3'b000, 3'b000, 2'd2, 1'b0);
        reset = 1'b0;
        $display("async reset transaction checked at %0t", $time);
        phase_seq(0, 1'b1);
        phase_seq(1, 1'b0);

        // Randomised enable/flash/demand with invariant checks every cycle.
        prev_r = R; prev_y = Y; prev_g = G;
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) flash_req = ~flash_req;
            demand = 3'($urandom_range(0, 7));
            step();
            if (R == 3'b000) begin
                ok = (G == 3'b000) && ((Y == 3'b000) || (Y == 3'b111));
            end else begin
                ok = $onehot0(G) && $onehot0(Y) && ((G & R) == 3'b000) && ((Y & R) == 3'b000)
                     && !((G != 3'b000) && (Y != 3'b000));
            end
            if ((G != 3'b000) && (prev_g == 3'b000)) begin
                ok = ok && (prev_r == 3'b111) && (prev_y == 3'b000);
            end
            chk($sformatf("invariant_cyc%0d", i), {11'd0, ok}, 12'd1);
            prev_r = R; prev_y = Y; prev_g = G;
        end
        $display("random invariant sweep checked at %0t", $time);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
